// File: rtl/ddr3_rd_control_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rd_control_if
// Purpose  : Read-command / read-data handshake between the fill read
//            controller and the DDR3 user interface.
// Signals  : ddr3_rd_addr      26  read address (controller -> memory)
//            rd_app_en          1  read command request
//            rd_app_rdy         1  command accepted when high with rd_app_en
//            app_rd_data      128  returned read data
//            app_rd_data_valid  1  returned data valid
// Modports : master = read controller, slave = memory user interface
// Revision : 1.0  initial release
// ============================================================================
interface ddr3_rd_control_if;
  logic [25:0]  ddr3_rd_addr;
  logic         rd_app_en;
  logic         rd_app_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;

  modport master (
    output ddr3_rd_addr,
    output rd_app_en,
    input  rd_app_rdy,
    input  app_rd_data,
    input  app_rd_data_valid
  );

  modport slave (
    input  ddr3_rd_addr,
    input  rd_app_en,
    output rd_app_rdy,
    output app_rd_data,
    output app_rd_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/ddr3_rd_control.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rd_control
// Purpose  : Pops a fill header, validates its tag, then issues burst+2 DDR3
//            read commands (header + payload + checksum) with a bounded number
//            of commands in flight, forwarding returned words to the readout
//            FIFO with one cycle of latency.
// Ports    : clk, reset_n                 clock, async active-low reset
//            readout_enabled              readout permitted
//            fill_header_fifo_*           FWFT header FIFO head/empty/pop
//            mem (ddr3_rd_control_if)     read command / read data handshake
//            rd_out_fifo_*                readout FIFO data/write/prog_full
//            ddr3_rd_busy                 state is not IDLE
//            ddr3_rd_sync_err             header tag invalid (until reset)
//            ddr3_rd_hdr_err              first word != header (sticky)
// Options  : DDR3_RD_HDR_CHECK_EN - enables the first-word header comparator;
//            when undefined ddr3_rd_hdr_err is tied low.
// Revision : 1.0  initial release
// ============================================================================
module ddr3_rd_control #(
  parameter int MAX_OUTSTANDING = 16  // 1..31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              readout_enabled,
  input  logic [127:0]      fill_header_fifo_dat,
  input  logic              fill_header_fifo_empty,
  output logic              fill_header_fifo_rd_en,
  ddr3_rd_control_if.master mem,
  output logic [127:0]      rd_out_fifo_dat,
  output logic              rd_out_fifo_wr_en,
  input  logic              rd_out_fifo_prog_full,
  output logic              ddr3_rd_busy,
  output logic              ddr3_rd_sync_err,
  output logic              ddr3_rd_hdr_err
);

  localparam logic [4:0] C_MAX = 5'(MAX_OUTSTANDING);

  typedef enum logic [6:0] {
    S_IDLE     = 7'b0000001,
    S_TST_HDR  = 7'b0000010,
    S_SYNC_ERR = 7'b0000100,
    S_INIT     = 7'b0001000,
    S_READ     = 7'b0010000,
    S_DRAIN    = 7'b0100000,
    S_DONE     = 7'b1000000
  } state_t;

  state_t       r_state;
  logic [22:0]  r_hdr_addr;
  logic [20:0]  r_hdr_burst;
  logic [22:0]  r_addr_gen;
  logic [21:0]  r_issue;     // commands still to issue (burst + 2 max)
  logic [21:0]  r_ret;       // words still to return for this fill
  logic [4:0]   r_out;       // commands accepted, data not yet returned
  logic         r_busy;
  logic         r_sync_err;
  logic         r_pop;
  logic [127:0] r_out_dat;
  logic         r_out_wr;

  logic         w_app_en;
  logic         w_accept;
  logic         w_valid;

  assign w_valid = mem.app_rd_data_valid;

  // The command request is a decode of registered state so the handshake
  // always sees the live counters; it cannot rise outside READ.
  assign w_app_en = (r_state == S_READ) && (r_issue != 22'd0) &&
                    (r_out < C_MAX) && !rd_out_fifo_prog_full;
  assign w_accept = w_app_en && mem.rd_app_rdy;

  assign mem.rd_app_en    = w_app_en;
  assign mem.ddr3_rd_addr = {r_addr_gen, 3'b000};

  assign fill_header_fifo_rd_en = r_pop;
  assign ddr3_rd_busy           = r_busy;
  assign ddr3_rd_sync_err       = r_sync_err;
  assign rd_out_fifo_dat        = r_out_dat;
  assign rd_out_fifo_wr_en      = r_out_wr;

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_sync_err  <= 1'b0;
      r_pop       <= 1'b0;
      r_hdr_addr  <= '0;
      r_hdr_burst <= '0;
    end else begin
      r_pop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (readout_enabled && !fill_header_fifo_empty) begin
            r_state <= S_TST_HDR;
            r_busy  <= 1'b1;
          end
        end
        S_TST_HDR: begin
          r_hdr_addr  <= fill_header_fifo_dat[57:35];
          r_hdr_burst <= fill_header_fifo_dat[84:64];
          if (fill_header_fifo_dat[127:126] == 2'b01) begin
            r_state <= S_INIT;
          end else begin
            r_state    <= S_SYNC_ERR;
            r_sync_err <= 1'b1;
          end
        end
        S_SYNC_ERR: r_state <= S_SYNC_ERR;
        S_INIT:     r_state <= S_READ;
        S_READ: begin
          if ((r_issue == 22'd0) && (r_ret == 22'd0)) begin
            r_state <= S_DONE;
            r_pop   <= 1'b1;
          end else if (!readout_enabled && (r_issue != 22'd0)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Abandoned fill: header stays in the FIFO for a later retry.
          if (r_out == 5'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Address generator and fill counters. Return-side decrements saturate at
  // zero so stale data arriving after a mid-fill reset is harmless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr_gen <= '0;
      r_issue    <= '0;
      r_ret      <= '0;
      r_out      <= '0;
    end else begin
      if (r_state == S_INIT) begin
        r_addr_gen <= r_hdr_addr;
        r_issue    <= {1'b0, r_hdr_burst} + 22'd2;
        r_ret      <= {1'b0, r_hdr_burst} + 22'd2;
      end else begin
        if (w_accept) begin
          r_addr_gen <= r_addr_gen + 23'd1;  // wraps naturally at 7FFFFF
          r_issue    <= r_issue - 22'd1;
        end
        if (w_valid && (r_ret != 22'd0)) begin
          r_ret <= r_ret - 22'd1;
        end
      end
      case ({w_accept, w_valid})
        2'b10:   r_out <= r_out + 5'd1;
        2'b01:   if (r_out != 5'd0) r_out <= r_out - 5'd1;
        default: r_out <= r_out;
      endcase
    end
  end

  // Readout FIFO forwarding, latency 1, in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_dat <= '0;
      r_out_wr  <= 1'b0;
    end else begin
      r_out_dat <= mem.app_rd_data;
      r_out_wr  <= w_valid;
    end
  end

`ifdef DDR3_RD_HDR_CHECK_EN
  logic [127:0] r_hdr_word;
  logic         r_first_pend;  // next returned word is the fill's first
  logic         r_hdr_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hdr_word   <= '0;
      r_first_pend <= 1'b0;
      r_hdr_err    <= 1'b0;
    end else begin
      if (r_state == S_TST_HDR) begin
        r_hdr_word <= fill_header_fifo_dat;
      end
      if (r_state == S_INIT) begin
        r_first_pend <= 1'b1;
      end else if (w_valid && r_first_pend) begin
        r_first_pend <= 1'b0;
        if (mem.app_rd_data != r_hdr_word) begin
          r_hdr_err <= 1'b1;
        end
      end
    end
  end

  assign ddr3_rd_hdr_err = r_hdr_err;
`else
  logic w_unused_hdr_bits;
  assign w_unused_hdr_bits = ^{fill_header_fifo_dat[125:85],
                               fill_header_fifo_dat[63:58],
                               fill_header_fifo_dat[34:0]};
  assign ddr3_rd_hdr_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_rd_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_rd_control
// Purpose  : Directed self-checking bench for ddr3_rd_control (built with
//            MAX_OUTSTANDING=4). A small memory model records accepted
//            command addresses and returns words one cycle after acceptance
//            when returns are enabled; the first word of a fill echoes the
//            header. Honours DDR3_RD_HDR_CHECK_EN for the header-check case.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr3_rd_control;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         readout_enabled;
  logic [127:0] hdr_dat;
  logic         hdr_empty;
  logic         hdr_pop;
  logic [127:0] rd_out_fifo_dat;
  logic         rd_out_fifo_wr_en;
  logic         prog_full;
  logic         ddr3_rd_busy;
  logic         ddr3_rd_sync_err;
  logic         ddr3_rd_hdr_err;

  ddr3_rd_control_if mem ();

  ddr3_rd_control #(.MAX_OUTSTANDING(4)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .readout_enabled        (readout_enabled),
    .fill_header_fifo_dat   (hdr_dat),
    .fill_header_fifo_empty (hdr_empty),
    .fill_header_fifo_rd_en (hdr_pop),
    .mem                    (mem),
    .rd_out_fifo_dat        (rd_out_fifo_dat),
    .rd_out_fifo_wr_en      (rd_out_fifo_wr_en),
    .rd_out_fifo_prog_full  (prog_full),
    .ddr3_rd_busy           (ddr3_rd_busy),
    .ddr3_rd_sync_err       (ddr3_rd_sync_err),
    .ddr3_rd_hdr_err        (ddr3_rd_hdr_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [25:0]  addr_log [$];
  logic [127:0] pend     [$];
  logic [127:0] fwd_exp  [$];
  int cmds, pops, fwd_cnt, rdy_lim;
  bit ret_on, corrupt, seen_busy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] make_hdr(input logic [1:0] tag, input logic [22:0] a,
                                           input logic [20:0] b);
    logic [127:0] h;
    h          = '0;
    h[31:0]    = 32'hA5A5_0001;
    h[127:126] = tag;
    h[57:35]   = a;
    h[84:64]   = b;
    return h;
  endfunction

  // One clock: observe outputs at the falling edge, then drive inputs for
  // the next rising edge and log any command that edge will accept.
  task automatic step();
    logic [127:0] d;
    @(negedge clk);
    seen_busy = seen_busy | ddr3_rd_busy;
    if (rd_out_fifo_wr_en) begin
      fwd_cnt++;
      if (fwd_exp.size() > 0) chk("fwd_dat", rd_out_fifo_dat, fwd_exp.pop_front());
      else chk("fwd_unexpected", rd_out_fifo_wr_en, 0);
    end
    if (hdr_pop) begin
      pops++;
      hdr_empty = 1'b1;
    end
    mem.rd_app_rdy = (cmds < rdy_lim);
    if (ret_on && pend.size() > 0) begin
      d = pend.pop_front();
      mem.app_rd_data_valid = 1'b1;
      mem.app_rd_data       = d;
      fwd_exp.push_back(d);
    end else begin
      mem.app_rd_data_valid = 1'b0;
      mem.app_rd_data       = '0;
    end
    #1;
    if (mem.rd_app_en && mem.rd_app_rdy) begin
      addr_log.push_back(mem.ddr3_rd_addr);
      d = (cmds == 0) ? (hdr_dat ^ {127'h0, corrupt}) : {102'h0, mem.ddr3_rd_addr};
      pend.push_back(d);
      cmds++;
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    fwd_exp.delete();
    cmds = 0; pops = 0; fwd_cnt = 0; seen_busy = 0;
  endtask

  task automatic do_reset(input bit keep_pend);
    reset_n = 1'b0;
    readout_enabled = 1'b0;
    hdr_empty = 1'b1;
    prog_full = 1'b0;
    mem.rd_app_rdy = 1'b0;
    mem.app_rd_data_valid = 1'b0;
    mem.app_rd_data = '0;
    if (!keep_pend) pend.delete();
    clear_logs();
    rdy_lim = 1000; ret_on = 0; corrupt = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic start_fill(input logic [127:0] h);
    clear_logs();
    hdr_dat = h;
    hdr_empty = 1'b0;
    readout_enabled = 1'b1;
  endtask

  task automatic run_until_quiet(input int max_cyc, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(seen_busy && !ddr3_rd_busy) && n < max_cyc);
    if (!(seen_busy && !ddr3_rd_busy)) chk({tag, "_timeout"}, ddr3_rd_busy, 0);
  endtask

  initial begin
    hdr_dat = '0;
    do_reset(0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", ddr3_rd_busy, 0);
    chk("rst_sync", ddr3_rd_sync_err, 0);
    chk("rst_hdrerr", ddr3_rd_hdr_err, 0);
    chk("rst_app_en", mem.rd_app_en, 0);
    chk("rst_pop", hdr_pop, 0);
    chk("rst_wr_en", rd_out_fifo_wr_en, 0);
    chk("rst_addr", mem.ddr3_rd_addr, 0);
    reset_n = 1'b1;

    // Basic fill: addr 0x10, burst 3 -> 5 commands 0x80..0xA0.
    ret_on = 1;
    start_fill(make_hdr(2'b01, 23'h000010, 21'd3));
    run_until_quiet(100, "basic");
    chk("basic_cmds", cmds, 5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++)
      chk($sformatf("basic_addr%0d", i), addr_log[i], 26'h80 + 26'(8 * i));
    chk("basic_fwd", fwd_cnt, 5);
    chk("basic_pops", pops, 1);
    chk("basic_busy", ddr3_rd_busy, 0);
    chk("basic_hdrerr", ddr3_rd_hdr_err, 0);

    // Address wrap: 7FFFFE, burst 1.
    do_reset(0);
    ret_on = 1;
    start_fill(make_hdr(2'b01, 23'h7FFFFE, 21'd1));
    run_until_quiet(100, "wrap");
    chk("wrap_cmds", cmds, 3);
    if (addr_log.size() == 3) begin
      chk("wrap_a0", addr_log[0], 26'h3FFFFF0);
      chk("wrap_a1", addr_log[1], 26'h3FFFFF8);
      chk("wrap_a2", addr_log[2], 26'h0000000);
    end
    chk("wrap_pops", pops, 1);

    // Outstanding limit: burst 10 with no returns stalls at 4 commands.
    do_reset(0);
    start_fill(make_hdr(2'b01, 23'h000100, 21'd10));
    repeat (20) step();
    chk("lim_cmds", cmds, 4);
    chk("lim_app_en", mem.rd_app_en, 0);
    chk("lim_busy", ddr3_rd_busy, 1);
    ret_on = 1;
    run_until_quiet(200, "lim");
    chk("lim_cmds_total", cmds, 12);
    chk("lim_fwd", fwd_cnt, 12);
    chk("lim_pops", pops, 1);

    // Drain: 6 commands wanted, enable dropped after 2 accepted.
    do_reset(0);
    rdy_lim = 2;
    start_fill(make_hdr(2'b01, 23'h000200, 21'd4));
    for (int i = 0; i < 30 && cmds < 2; i++) step();
    chk("drain_cmds_pre", cmds, 2);
    readout_enabled = 1'b0;
    repeat (5) step();
    chk("drain_busy", ddr3_rd_busy, 1);
    chk("drain_app_en", mem.rd_app_en, 0);
    ret_on = 1;
    run_until_quiet(50, "drain");
    chk("drain_fwd", fwd_cnt, 2);
    chk("drain_cmds", cmds, 2);
    chk("drain_pops", pops, 0);

    // Header check: first returned word differs in bit 0.
    begin
      logic pre_err;
      do_reset(0);
      ret_on = 1;
      corrupt = 1;
      pre_err = 1'b0;
      start_fill(make_hdr(2'b01, 23'h000020, 21'd0));
      for (int i = 0; i < 40 && fwd_cnt < 1; i++) begin
        pre_err = pre_err | ddr3_rd_hdr_err;
        step();
      end
      chk("hchk_pre", pre_err, 0);
`ifdef DDR3_RD_HDR_CHECK_EN
      chk("hchk_err", ddr3_rd_hdr_err, 1);
`else
      chk("hchk_err", ddr3_rd_hdr_err, 0);
`endif
      run_until_quiet(50, "hchk");
`ifdef DDR3_RD_HDR_CHECK_EN
      chk("hchk_sticky", ddr3_rd_hdr_err, 1);
`else
      chk("hchk_sticky", ddr3_rd_hdr_err, 0);
`endif
    end

    // Reset mid-READ: stale data still forwarded, counters must not underflow.
    do_reset(0);
    start_fill(make_hdr(2'b01, 23'h000300, 21'd6));
    for (int i = 0; i < 30 && cmds < 3; i++) step();
    do_reset(1);
    ret_on = 1;
    repeat (8) step();
    chk("stale_fwd", fwd_cnt, 3);
    chk("stale_busy", ddr3_rd_busy, 0);
    chk("stale_app_en", mem.rd_app_en, 0);
    chk("stale_hdrerr", ddr3_rd_hdr_err, 0);
    start_fill(make_hdr(2'b01, 23'h000040, 21'd0));
    run_until_quiet(60, "post");
    chk("post_cmds", cmds, 2);
    chk("post_fwd", fwd_cnt, 2);
    chk("post_pops", pops, 1);

    // Bad tag: sync error forever, nothing issued, no pop.
    do_reset(0);
    ret_on = 1;
    start_fill(make_hdr(2'b10, 23'h000010, 21'd3));
    repeat (10) step();
    chk("sync_err", ddr3_rd_sync_err, 1);
    chk("sync_busy", ddr3_rd_busy, 1);
    repeat (10) step();
    chk("sync_err_hold", ddr3_rd_sync_err, 1);
    chk("sync_cmds", cmds, 0);
    chk("sync_pops", pops, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr3_rd_control.md
DDR3_RD_CONTROL -- requirements
Module: ddr3_rd_control

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 16, meaning the maximum number of read addresses accepted whose data has not yet returned (range 1..31).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low, with ports named as follows:
- clk  in  1  DDR3 user-interface clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
REQ-003 The block SHALL have the following control ports:
- readout_enabled  in  1  readout permitted.
- fill_header_fifo_dat  in  128  head of fill-header FIFO (first-word fall-through).
- fill_header_fifo_empty  in  1  header FIFO empty.
- fill_header_fifo_rd_en  out  1  pop header.
REQ-004 The block SHALL have the following memory-side ports:
- ddr3_rd_addr  out  26  read address.
- rd_app_en  out  1  read command request.
- rd_app_rdy  in  1  command accepted when high with rd_app_en.
- app_rd_data  in  128  returned read data.
- app_rd_data_valid  in  1  returned data valid.
REQ-005 The block SHALL have the following output-FIFO and status ports:
- rd_out_fifo_dat  out  128  data to readout FIFO.
- rd_out_fifo_wr_en  out  1  write readout FIFO.
- rd_out_fifo_prog_full  in  1  readout FIFO cannot absorb MAX_OUTSTANDING more words.
- ddr3_rd_busy  out  1  high when state is not IDLE.
- ddr3_rd_sync_err  out  1  header tag invalid.
- ddr3_rd_hdr_err  out  1  first read word differs from fill header (sticky until reset).

Function
REQ-006 Header fields SHALL be: tag [127:126] (valid = 2'b01), start address [57:35] (23 bits), burst count [84:64] (21 bits); words to read N = burst count + 2 (header plus checksum).
REQ-007 States SHALL be IDLE, TST_HDR, SYNC_ERR, INIT, READ, DRAIN and DONE, one-hot encoded.
REQ-008 IDLE SHALL go to TST_HDR when readout_enabled=1 and fill_header_fifo_empty=0; otherwise it stays in IDLE.
REQ-009 TST_HDR SHALL latch the header and go to INIT if the tag is 2'b01, else to SYNC_ERR.
REQ-010 SYNC_ERR SHALL hold ddr3_rd_sync_err=1 and remain in SYNC_ERR until reset.
REQ-011 INIT SHALL load the 23-bit address generator, the issue counter (N) and the return counter (N) in one cycle, then go to READ.
REQ-012 In READ, rd_app_en SHALL be high only when:
- the issue counter is nonzero;
- the outstanding count is below MAX_OUTSTANDING;
- rd_out_fifo_prog_full=0.
REQ-013 ddr3_rd_addr SHALL be {addr_gen, 3'b000}.
REQ-014 On each cycle with rd_app_en & rd_app_rdy, the block SHALL increment addr_gen, decrement the issue counter and increment the outstanding count.
REQ-015 addr_gen SHALL wrap from 23'h7FFFFF to 0 without error.
REQ-016 On each app_rd_data_valid, in any state, the block SHALL decrement the outstanding count and the return counter.
REQ-017 When a command is accepted and data returns in the same cycle, the outstanding count SHALL be unchanged.
REQ-018 rd_out_fifo_dat and rd_out_fifo_wr_en SHALL be app_rd_data and app_rd_data_valid registered one cycle (latency 1).
REQ-019 READ SHALL go to DONE when the issue counter is 0 and the return counter is 0.
REQ-020 READ SHALL go to DRAIN if readout_enabled falls while the issue counter is nonzero.
REQ-021 DRAIN SHALL issue no commands and SHALL go to IDLE, without popping the header, when the outstanding count is 0.
REQ-022 DONE SHALL assert fill_header_fifo_rd_en for exactly one cycle, then go to IDLE.
REQ-023 rd_app_en SHALL be low outside READ.
REQ-024 A rd_app_rdy that arrives without rd_app_en SHALL be ignored.
REQ-025 The block SHALL never assert rd_app_en while the outstanding count equals MAX_OUTSTANDING.

Reset
REQ-026 reset_n=0 SHALL asynchronously force the following:
- state to IDLE;
- all counters and addr_gen to 0;
- all outputs to 0, including ddr3_rd_busy, both error flags and fill_header_fifo_rd_en.
REQ-027 Reset mid-READ SHALL discard outstanding accounting; data returned after release SHALL still be forwarded to the readout FIFO but SHALL NOT underflow counters, which saturate at 0.

Configuration
REQ-028 With DDR3_RD_HDR_CHECK_EN defined, the block SHALL compare the first word returned per fill against the latched header and set ddr3_rd_hdr_err on mismatch; without the macro, ddr3_rd_hdr_err SHALL be tied to 0 and no comparator SHALL exist.

Verification
REQ-029 Header with tag 01, address 23'h000010 and burst 3 -> 5 commands at addresses 0x80, 0x88, 0x90, 0x98, 0xA0; 5 words forwarded; one fill_header_fifo_rd_en pulse; ddr3_rd_busy returns to 0.
REQ-030 Header with tag 2'b10 -> ddr3_rd_sync_err=1 persistently, no commands issued, no header pop.
REQ-031 MAX_OUTSTANDING=4, burst 10, no data returned -> exactly 4 commands accepted, then rd_app_en held low until data returns.
REQ-032 Start address 23'h7FFFFE, burst 1 -> addresses 0x3FFFFF0, 0x3FFFFF8, 0x0000000.
REQ-033 readout_enabled dropped after 2 of 6 commands -> DRAIN entered; IDLE reached after 2 words returned; header not popped.
REQ-034 With DDR3_RD_HDR_CHECK_EN defined, first returned word differs from the header in bit 0 -> ddr3_rd_hdr_err=1 one cycle after that word.
